// File: rtl/iram_loader_if.sv
// SPI host pins and instruction-RAM write port of the boot loader.
// The loader takes the master modport; the host/system side takes slave.
interface iram_loader_if #(
    parameter int ADDR_W = 13
) ();
    logic              nCS;
    logic              SCK;
    logic              MOSI;
    logic              cpu_hold;
    logic              iram_we;
    logic [ADDR_W-1:0] iram_waddr;
    logic [15:0]       iram_wdata;
    logic              busy;

    modport master (
        input  nCS, SCK, MOSI,
        output cpu_hold, iram_we, iram_waddr, iram_wdata, busy
    );

    modport slave (
        output nCS, SCK, MOSI,
        input  cpu_hold, iram_we, iram_waddr, iram_wdata, busy
    );
endinterface

// File: rtl/iram_loader.sv
// SPI mode-0 slave that loads 16-bit words into instruction RAM and
// holds/releases the CPU via LOAD/RUN/HALT/NOP command words.
module iram_loader #(
    parameter int ADDR_W        = 13,
    parameter bit HOLD_ON_RESET = 1'b1
) (
    input logic            clk,
    input logic            reset,
    iram_loader_if.master  bus
);
    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] CMD    = 2'd1;
    localparam logic [1:0] DATA   = 2'd2;
    localparam logic [1:0] IGNORE = 2'd3;

    // [1:0] is the synchronizer, [2] the previous synchronized value
    logic [2:0]        ncs_q, ncs_d;
    logic [2:0]        sck_q, sck_d;
    logic [1:0]        mosi_q, mosi_d;
    logic [1:0]        state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [15:0]       shift_q, shift_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              hold_q, hold_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] waddr_q, waddr_d;
    logic [15:0]       wdata_q, wdata_d;
    logic              busy_q, busy_d;

    logic        ncs_fall, ncs_rise, sck_rise;
    logic [15:0] word;

    assign ncs_d  = {ncs_q[1:0], bus.nCS};
    assign sck_d  = {sck_q[1:0], bus.SCK};
    assign mosi_d = {mosi_q[0], bus.MOSI};

    assign ncs_fall = ncs_q[2] & ~ncs_q[1];
    assign ncs_rise = ~ncs_q[2] & ncs_q[1];
    assign sck_rise = ~sck_q[2] & sck_q[1];
    assign word     = {shift_q[14:0], mosi_q[1]};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        shift_d = shift_q;
        addr_d  = addr_q;
        hold_d  = hold_q;
        we_d    = 1'b0;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        busy_d  = busy_q;
        // frame end wins over a word completing in the same cycle
        if (ncs_rise) begin
            state_d = IDLE;
            busy_d  = 1'b0;
        end else if (state_q == IDLE) begin
            if (ncs_fall) begin
                state_d = CMD;
                cnt_d   = 4'd0;
                shift_d = 16'h0000;
                busy_d  = 1'b1;
            end
        end else if (sck_rise) begin
            shift_d = word;
            cnt_d   = cnt_q + 4'd1;
            if (cnt_q == 4'hf) begin
                unique case (state_q)
                    CMD: begin
                        unique case (word[15:14])
                            2'b00: state_d = IGNORE;
                            2'b01: begin
                                state_d = DATA;
                                addr_d  = word[ADDR_W-1:0];
                                hold_d  = 1'b1;
                            end
                            2'b10: begin
                                state_d = IGNORE;
                                hold_d  = 1'b0;
                            end
                            default: begin
                                state_d = IGNORE;
                                hold_d  = 1'b1;
                            end
                        endcase
                    end
                    DATA: begin
                        if (hold_q) begin
                            we_d    = 1'b1;
                            waddr_d = addr_q;
                            wdata_d = word;
                            addr_d  = addr_q + 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ncs_q   <= '0;
            sck_q   <= '0;
            mosi_q  <= '0;
            state_q <= IDLE;
            cnt_q   <= '0;
            shift_q <= '0;
            addr_q  <= '0;
            hold_q  <= HOLD_ON_RESET;
            we_q    <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
            busy_q  <= 1'b0;
        end else begin
            ncs_q   <= ncs_d;
            sck_q   <= sck_d;
            mosi_q  <= mosi_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
            addr_q  <= addr_d;
            hold_q  <= hold_d;
            we_q    <= we_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
            busy_q  <= busy_d;
        end
    end

    assign bus.cpu_hold   = hold_q;
    assign bus.iram_we    = we_q;
    assign bus.iram_waddr = waddr_q;
    assign bus.iram_wdata = wdata_q;
    assign bus.busy       = busy_q;
endmodule

// File: doc/iram_loader.md
IRAM_LOADER -- requirements
Module: iram_loader

Interface
REQ-001 Parameter ADDR_W, default 13, meaning: instruction RAM word-address width.
REQ-002 Parameter HOLD_ON_RESET, default 1, meaning: cpu_hold value after reset.
REQ-003 Port clk, input, 1, meaning: system clock; all state updates on its rising edge.
REQ-004 Port reset, input, 1, meaning: asynchronous, active-low reset (asserted at 0).
REQ-005 Port nCS, input, 1, meaning: SPI chip select, active-low, asynchronous to clk.
REQ-006 Port SCK, input, 1, meaning: SPI clock, asynchronous to clk.
REQ-007 Port MOSI, input, 1, meaning: SPI serial data in, asynchronous to clk.
REQ-008 Port cpu_hold, output, 1, meaning: 1 holds the CPU in reset and grants iram write port to loader.
REQ-009 Port iram_we, output, 1, meaning: single-cycle iram write strobe.
REQ-010 Port iram_waddr, output, ADDR_W, meaning: iram write word address.
REQ-011 Port iram_wdata, output, 16, meaning: iram write data.
REQ-012 Port busy, output, 1, meaning: 1 while a frame is active (nCS low after sync).

Function
REQ-013 nCS, SCK and MOSI SHALL each pass through a 2-flop synchronizer before use; edges SHALL be detected on synchronized signals.
REQ-014 SPI mode 0: MOSI SHALL be sampled on synchronized SCK rising edge, MSB first, into a 16-bit shift register with 4-bit bit counter.
REQ-015 Host timing contract: SCK high and low phases each >= 3 clk periods; violations are unsupported.
REQ-016 States SHALL be IDLE, CMD, DATA, IGNORE.
REQ-017 IDLE -> CMD on synchronized nCS falling; bit counter and shift register cleared; busy=1.
REQ-018 Any state -> IDLE on synchronized nCS rising; partial word discarded, no write issued; busy=0 next cycle.
REQ-019 CMD: on 16th bit, decode word[15:14]: 00 NOP -> IGNORE; 01 LOAD -> DATA, address register := word[ADDR_W-1:0], cpu_hold := 1; 10 RUN -> IGNORE, cpu_hold := 0; 11 HALT -> IGNORE, cpu_hold := 1.
REQ-020 cpu_hold changes SHALL take effect the clk cycle after the 16th-bit sample.
REQ-021 DATA: each completed 16-bit word SHALL produce exactly one iram_we pulse the following clk cycle, with iram_wdata = word, iram_waddr = address register.
REQ-022 Address register SHALL increment by 1 after each write, wrapping from 2^ADDR_W-1 to 0.
REQ-023 IGNORE: further bits shifted but no writes or hold changes until frame end.
REQ-024 iram_we SHALL never assert while cpu_hold=0.
REQ-025 iram_waddr/iram_wdata SHALL hold last values when iram_we=0.
REQ-026 nCS rising in same cycle as 16th-bit completion: frame end takes priority; word discarded.

Reset
REQ-027 On reset=0: state IDLE, cpu_hold=HOLD_ON_RESET, iram_we=0, iram_waddr=0, iram_wdata=0, busy=0, shift register, bit counter, address register and synchronizers cleared.
REQ-028 Reset mid-frame SHALL abort the frame; after release loader waits for a fresh nCS falling edge (nCS low at release is not a frame start).

Verification
REQ-029 Reset, frame LOAD 0x4000 then words 0x8003, 0x8101, 0x0DC0 -> three iram_we pulses at addr 0,1,2 with those data; cpu_hold=1 throughout.
REQ-030 Frame RUN 0x8000 -> cpu_hold falls one cycle after 16th bit; no iram_we.
REQ-031 Frame LOAD 0x5FFF (ADDR_W=13) then 0x1111, 0x2222 -> writes at 0x1FFF then 0x0000.
REQ-032 LOAD 0x4010, one full word 0xABCD, then 7 bits and nCS high -> single write addr 0x10 data 0xABCD; no second write.
REQ-033 HALT 0xC000 while running -> cpu_hold=1; NOP 0x0000 -> no state change; busy tracks nCS with 2-3 cycle lag.
REQ-034 reset=0 asserted after 9 bits of a LOAD data word -> outputs at reset values immediately; next frame starts cleanly.
